// File: rtl/carrier_pll_loop_if.sv
// rtl/carrier_pll_loop_if.sv - symbol input and loop output bundle for the carrier PLL
interface carrier_pll_loop_if #(
   parameter int WIDTH       = 16,
   parameter int PHASE_WIDTH = 32
);
   logic                    loop_en;
   logic [PHASE_WIDTH-1:0]  freq_init;
   logic                    sym_valid_in;
   logic signed [WIDTH-1:0] din_i;
   logic signed [WIDTH-1:0] din_q;
   logic signed [WIDTH+1:0] err_out;
   logic                    err_valid;
   logic [PHASE_WIDTH-1:0]  freq_out;
   logic [PHASE_WIDTH-1:0]  phase_out;
   logic                    lock;

   modport master (
      output loop_en, freq_init, sym_valid_in, din_i, din_q,
      input  err_out, err_valid, freq_out, phase_out, lock
   );

   modport slave (
      input  loop_en, freq_init, sym_valid_in, din_i, din_q,
      output err_out, err_valid, freq_out, phase_out, lock
   );
endinterface

// File: rtl/carrier_pll_loop.sv
// rtl/carrier_pll_loop.sv - decision-directed carrier recovery: phase detector, PI filter, NCO, lock detect
module carrier_pll_loop #(
   parameter int WIDTH       = 16,
   parameter int PHASE_WIDTH = 32,
   parameter int KP_SHIFT    = 10,
   parameter int KI_SHIFT    = 2,
   parameter int LOCK_THR    = 64,
   parameter int LOCK_CNT    = 16
) (
   input logic               clk,
   input logic               rst,
   carrier_pll_loop_if.slave bus
);
   localparam int EW = WIDTH + 2;
   localparam int KW = EW + KI_SHIFT;
   localparam int SW = ((KW > PHASE_WIDTH) ? KW : PHASE_WIDTH) + 1;
   localparam int CW = $clog2(LOCK_CNT + 1);
   localparam logic signed [SW-1:0] INTEG_MAX = SW'({1'b0, {(PHASE_WIDTH-1){1'b1}}});
   localparam logic signed [SW-1:0] INTEG_MIN = ~INTEG_MAX;

   logic signed [EW-1:0]          err_q, err_d;
   logic                          err_valid_q, err_valid_d;
   logic signed [PHASE_WIDTH-1:0] integ_q, integ_d;
   logic [PHASE_WIDTH-1:0]        freq_q, freq_d;
   logic [PHASE_WIDTH-1:0]        phase_q, phase_d;
   logic [CW-1:0]                 cnt_q, cnt_d;
   logic                          lock_q, lock_d;

   logic signed [EW-1:0]   di_x, dq_x, term_i, term_q;
   logic                   upd;
   logic signed [SW-1:0]   sum_w;
   logic [PHASE_WIDTH-1:0] prop;
   logic [EW-1:0]          err_mag;
   logic [CW-1:0]          cnt_inc;

   // Stage 1: hard-decision phase detector, sI*Q - sQ*I at full precision
   always_comb begin
      di_x        = EW'(bus.din_i);
      dq_x        = EW'(bus.din_q);
      term_i      = bus.din_i[WIDTH-1] ? -dq_x : dq_x;
      term_q      = bus.din_q[WIDTH-1] ? -di_x : di_x;
      err_valid_d = bus.sym_valid_in;
      err_d       = bus.sym_valid_in ? (term_i - term_q) : err_q;
   end

   // Stage 2: PI filter and NCO; the integrator clamps rather than wraps
   always_comb begin
      upd   = err_valid_q & bus.loop_en;
      sum_w = SW'(integ_q) + (SW'(err_q) <<< KI_SHIFT);
      prop  = PHASE_WIDTH'(err_q) <<< KP_SHIFT;
      if (!bus.loop_en) begin
         integ_d = '0;
      end else if (!upd) begin
         integ_d = integ_q;
      end else if (sum_w > INTEG_MAX) begin
         integ_d = INTEG_MAX[PHASE_WIDTH-1:0];
      end else if (sum_w < INTEG_MIN) begin
         integ_d = INTEG_MIN[PHASE_WIDTH-1:0];
      end else begin
         integ_d = sum_w[PHASE_WIDTH-1:0];
      end
      freq_d  = bus.freq_init + integ_d;
      phase_d = phase_q + freq_q + (upd ? prop : '0);
   end

   // Lock detector runs on every detector output, open or closed loop
   always_comb begin
      err_mag = err_q[EW-1] ? EW'(-err_q) : EW'(err_q);
      cnt_inc = (cnt_q == CW'(LOCK_CNT)) ? cnt_q : cnt_q + 1'b1;
      cnt_d   = cnt_q;
      lock_d  = lock_q;
      if (err_valid_q) begin
         if (err_mag < EW'(LOCK_THR)) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CW'(LOCK_CNT)) begin
               lock_d = 1'b1;
            end
         end else begin
            cnt_d  = '0;
            lock_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q       <= '0;
         err_valid_q <= 1'b0;
         integ_q     <= '0;
         freq_q      <= bus.freq_init;
         phase_q     <= '0;
         cnt_q       <= '0;
         lock_q      <= 1'b0;
      end else begin
         err_q       <= err_d;
         err_valid_q <= err_valid_d;
         integ_q     <= integ_d;
         freq_q      <= freq_d;
         phase_q     <= phase_d;
         cnt_q       <= cnt_d;
         lock_q      <= lock_d;
      end
   end

   assign bus.err_out   = err_q;
   assign bus.err_valid = err_valid_q;
   assign bus.freq_out  = freq_q;
   assign bus.phase_out = phase_q;
   assign bus.lock      = lock_q;
endmodule

// File: tb/tb_carrier_pll_loop.sv
// tb/tb_carrier_pll_loop.sv - self-checking bench for carrier_pll_loop
module tb_carrier_pll_loop;
   localparam int W  = 16;
   localparam int PW = 32;
   localparam logic [31:0] F = 32'h0100_0000;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   exp_q[$];

   always #5 clk = ~clk;

   carrier_pll_loop_if #(.WIDTH(W), .PHASE_WIDTH(PW)) if1 ();
   carrier_pll_loop_if #(.WIDTH(W), .PHASE_WIDTH(PW)) if2 ();

   assign if2.loop_en      = if1.loop_en;
   assign if2.freq_init    = if1.freq_init;
   assign if2.sym_valid_in = if1.sym_valid_in;
   assign if2.din_i        = if1.din_i;
   assign if2.din_q        = if1.din_q;

   carrier_pll_loop #(
      .WIDTH(W), .PHASE_WIDTH(PW), .KP_SHIFT(10), .KI_SHIFT(2), .LOCK_THR(64), .LOCK_CNT(16)
   ) dut (
      .clk(clk), .rst(rst), .bus(if1)
   );

   carrier_pll_loop #(
      .WIDTH(W), .PHASE_WIDTH(PW), .KP_SHIFT(10), .KI_SHIFT(14), .LOCK_THR(64), .LOCK_CNT(16)
   ) dut_sat (
      .clk(clk), .rst(rst), .bus(if2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int di, input int dq);
      int si, sq;
      si = (di >= 0) ? 1 : -1;
      sq = (dq >= 0) ? 1 : -1;
      if1.din_i        = 16'(di);
      if1.din_q        = 16'(dq);
      if1.sym_valid_in = 1'b1;
      exp_q.push_back(si * dq - sq * di);
      tick();
   endtask

   task automatic do_reset(input logic [31:0] fi, input logic en);
      rst              = 1'b1;
      if1.freq_init    = fi;
      if1.loop_en      = en;
      if1.sym_valid_in = 1'b0;
      if1.din_i        = '0;
      if1.din_q        = '0;
      repeat (3) tick();
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic monitor();
      int e;
      logic signed [17:0] e18;
      forever begin
         @(negedge clk);
         if (if1.err_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL stray_err_valid: err_out=%0d with no strobe pending", if1.err_out);
            end else begin
               e   = exp_q.pop_front();
               e18 = 18'(e);
               if (if1.err_out !== e18) begin
                  n_fail++;
                  $display("FAIL err_out_value: got %0d want %0d", if1.err_out, e18);
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      rst              = 1'b1;
      if1.freq_init    = F;
      if1.loop_en      = 1'b0;
      if1.sym_valid_in = 1'b0;
      if1.din_i        = '0;
      if1.din_q        = '0;
      repeat (3) tick();
      n_checks++; if (if1.phase_out !== 32'h0) begin n_fail++; $display("FAIL rst_phase: got %h want 0", if1.phase_out); end
      n_checks++; if (if1.freq_out !== F) begin n_fail++; $display("FAIL rst_freq: got %h want %h", if1.freq_out, F); end
      n_checks++; if (if1.err_valid !== 1'b0) begin n_fail++; $display("FAIL rst_err_valid: got %b want 0", if1.err_valid); end
      n_checks++; if (if1.lock !== 1'b0) begin n_fail++; $display("FAIL rst_lock: got %b want 0", if1.lock); end
      rst = 1'b0;
      exp_q.delete();
      if1.loop_en = 1'b1;
      send(1200, 800);
      send(1000, 990);
      rst = 1'b1;
      tick();
      if1.sym_valid_in = 1'b0;
      n_checks++; if (if1.phase_out !== 32'h0) begin n_fail++; $display("FAIL midrst_phase: got %h want 0", if1.phase_out); end
      n_checks++; if (if1.freq_out !== F) begin n_fail++; $display("FAIL midrst_freq: got %h want %h", if1.freq_out, F); end
      n_checks++; if (if1.err_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_err_valid: got %b want 0", if1.err_valid); end
      n_checks++; if (if1.err_out !== 18'sd0) begin n_fail++; $display("FAIL midrst_err_out: got %0d want 0", if1.err_out); end
      rst = 1'b0;
      tick();
      n_checks++; if (if1.err_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_stray: got %b want 0", if1.err_valid); end
   endtask

   task automatic test_open_loop();
      logic [31:0] exp_ph;
      do_reset(F, 1'b0);
      exp_ph = '0;
      for (int i = 1; i <= 256; i++) begin
         tick();
         exp_ph = exp_ph + F;
         n_checks++;
         if (if1.phase_out !== exp_ph) begin
            n_fail++;
            $display("FAIL open_phase_%0d: got %h want %h", i, if1.phase_out, exp_ph);
         end
      end
      n_checks++; if (if1.phase_out !== 32'h0) begin n_fail++; $display("FAIL open_wrap: got %h want 0", if1.phase_out); end
   endtask

   task automatic test_phase_detector();
      logic signed [17:0] want;
      do_reset(F, 1'b0);
      send(1200, 800);
      if1.sym_valid_in = 1'b0;
      want = -18'sd400;
      n_checks++; if (if1.err_valid !== 1'b1) begin n_fail++; $display("FAIL pd_valid_n1: got %b want 1", if1.err_valid); end
      n_checks++; if (if1.err_out !== want) begin n_fail++; $display("FAIL pd_err_n1: got %0d want %0d", if1.err_out, want); end
      tick();
      n_checks++; if (if1.err_valid !== 1'b0) begin n_fail++; $display("FAIL pd_valid_n2: got %b want 0", if1.err_valid); end
      send(1000, 1000);
      if1.sym_valid_in = 1'b0;
      tick();
      send(-32768, 32767);
      if1.sym_valid_in = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_back_to_back();
      do_reset(F, 1'b0);
      send(1200, 800);
      send(1000, 990);
      send(-32768, 0);
      if1.sym_valid_in = 1'b0;
      n_checks++; if (if1.err_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_third_valid: got %b want 1", if1.err_valid); end
      tick();
      n_checks++; if (if1.err_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_after_valid: got %b want 0", if1.err_valid); end
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_drained: got %0d pending want 0", exp_q.size()); end
   endtask

   task automatic test_loop_update();
      logic [31:0] exp_ph, exp_fr;
      do_reset(F, 1'b1);
      send(1200, 800);
      if1.sym_valid_in = 1'b0;
      exp_ph = F;
      n_checks++; if (if1.phase_out !== exp_ph) begin n_fail++; $display("FAIL loop_phase_n1: got %h want %h", if1.phase_out, exp_ph); end
      n_checks++; if (if1.freq_out !== F) begin n_fail++; $display("FAIL loop_freq_n1: got %h want %h", if1.freq_out, F); end
      tick();
      exp_fr = F - 32'd1600;
      exp_ph = exp_ph + F - 32'd409600;
      n_checks++; if (if1.freq_out !== exp_fr) begin n_fail++; $display("FAIL loop_freq_n2: got %h want %h", if1.freq_out, exp_fr); end
      n_checks++; if (if1.phase_out !== exp_ph) begin n_fail++; $display("FAIL loop_phase_n2: got %h want %h", if1.phase_out, exp_ph); end
      for (int i = 3; i <= 5; i++) begin
         tick();
         exp_ph = exp_ph + exp_fr;
         n_checks++; if (if1.phase_out !== exp_ph) begin n_fail++; $display("FAIL loop_phase_n%0d: got %h want %h", i, if1.phase_out, exp_ph); end
      end
      n_checks++; if (if1.freq_out !== exp_fr) begin n_fail++; $display("FAIL loop_freq_hold: got %h want %h", if1.freq_out, exp_fr); end
   endtask

   task automatic test_saturation();
      longint      integ;
      int          applied;
      logic [31:0] exp_fr;
      do_reset(F, 1'b1);
      integ   = 0;
      applied = 0;
      for (int k = 0; k < 12; k++) begin
         if (k < 8) begin
            send(-32768, 0);
         end else begin
            if1.sym_valid_in = 1'b0;
            tick();
         end
         while (applied < ((k < 8) ? k : 8)) begin
            integ = integ + (longint'(32768) <<< 14);
            if (integ > 64'sd2147483647) integ = 64'sd2147483647;
            applied++;
         end
         exp_fr = F + 32'(integ);
         n_checks++;
         if (if2.freq_out !== exp_fr) begin
            n_fail++;
            $display("FAIL sat_freq_%0d: got %h want %h", k, if2.freq_out, exp_fr);
         end
      end
      n_checks++; if (if2.freq_out !== 32'h80FF_FFFF) begin n_fail++; $display("FAIL sat_final: got %h want 80ffffff", if2.freq_out); end
   endtask

   task automatic test_lock();
      do_reset(F, 1'b0);
      repeat (16) send(1000, 990);
      if1.sym_valid_in = 1'b0;
      n_checks++; if (if1.lock !== 1'b0) begin n_fail++; $display("FAIL lock_before: got %b want 0", if1.lock); end
      tick();
      n_checks++; if (if1.lock !== 1'b1) begin n_fail++; $display("FAIL lock_set: got %b want 1", if1.lock); end
      send(1000, 1100);
      if1.sym_valid_in = 1'b0;
      n_checks++; if (if1.lock !== 1'b1) begin n_fail++; $display("FAIL lock_hold_on_big: got %b want 1", if1.lock); end
      tick();
      n_checks++; if (if1.lock !== 1'b0) begin n_fail++; $display("FAIL lock_drop: got %b want 0", if1.lock); end
      repeat (15) send(1000, 990);
      if1.sym_valid_in = 1'b0;
      tick();
      n_checks++; if (if1.lock !== 1'b0) begin n_fail++; $display("FAIL lock_after_15: got %b want 0", if1.lock); end
      send(1000, 990);
      if1.sym_valid_in = 1'b0;
      tick();
      n_checks++; if (if1.lock !== 1'b1) begin n_fail++; $display("FAIL lock_relock: got %b want 1", if1.lock); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_open_loop();
      test_phase_detector();
      test_back_to_back();
      test_loop_update();
      test_saturation();
      test_lock();
      tick();
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_empty: got %0d pending want 0", exp_q.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
